// File: rtl/axis_pattern_master.sv
// axis_pattern_master: AXI4-Stream byte-pattern transmitter.
// Emits bursts of len beats (incrementing or 8-bit LFSR data) with an optional
// idle gap between beats. All outputs are registered; tvalid never depends
// combinationally on tready.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; tvalid low
// SEND  | tvalid high, holding tdata until the handshake
// GAP   | tvalid low, counting down the inter-beat idle cycles
module axis_pattern_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  len,
    input  logic [7:0]            gap,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0]  len_q, len_nxt;
    logic [7:0]            gap_q, gap_nxt;
    logic                  mode_q, mode_nxt;
    logic [7:0]            gap_cnt, gap_cnt_nxt;
    logic                  tvalid_q, tvalid_nxt;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_nxt;
    logic                  busy_q, busy_nxt;
    logic                  done_q, done_nxt;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_nxt;

    logic handshake;
    logic last_beat;

    assign handshake = tvalid_q & m_axis_tready;
    assign last_beat = (beat_cnt_q + CNT_WIDTH'(1)) == len_q;

    // Next pattern value: +1 with wrap, or the 8-bit Fibonacci LFSR (taps 7,5,4,3).
    function automatic logic [DATA_WIDTH-1:0] next_pattern(input logic m,
                                                           input logic [DATA_WIDTH-1:0] d);
        if (m)
            next_pattern = {d[DATA_WIDTH-2:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
        else
            next_pattern = d + DATA_WIDTH'(1);
    endfunction

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && (len != '0))
                    state_nxt = SEND;
            end
            SEND: begin
                if (handshake) begin
                    if (last_beat)
                        state_nxt = IDLE;
                    else if (gap_q != 8'd0)
                        state_nxt = GAP;
                end
            end
            GAP: begin
                // Leaving on count 1 makes tvalid rise after exactly gap idle cycles.
                if (gap_cnt <= 8'd1)
                    state_nxt = SEND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs and latched burst parameters.
    always_comb begin
        len_nxt      = len_q;
        gap_nxt      = gap_q;
        mode_nxt     = mode_q;
        gap_cnt_nxt  = gap_cnt;
        tvalid_nxt   = tvalid_q;
        tdata_nxt    = tdata_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
        beat_cnt_nxt = beat_cnt_q;
        case (state)
            IDLE: begin
                if (start) begin
                    beat_cnt_nxt = '0;
                    if (len != '0) begin
                        len_nxt    = len;
                        gap_nxt    = gap;
                        mode_nxt   = mode;
                        // An all-zero LFSR would lock up, so seed 0 starts at 1 instead.
                        tdata_nxt  = (mode && (seed == '0)) ? DATA_WIDTH'(1) : seed;
                        busy_nxt   = 1'b1;
                        tvalid_nxt = 1'b1;
                    end else begin
                        done_nxt   = 1'b1;
                    end
                end
            end
            SEND: begin
                if (handshake) begin
                    beat_cnt_nxt = beat_cnt_q + CNT_WIDTH'(1);
                    tdata_nxt    = next_pattern(mode_q, tdata_q);
                    if (last_beat) begin
                        tvalid_nxt = 1'b0;
                        busy_nxt   = 1'b0;
                        done_nxt   = 1'b1;
                    end else if (gap_q != 8'd0) begin
                        tvalid_nxt  = 1'b0;
                        gap_cnt_nxt = gap_q;
                    end
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt - 8'd1;
                if (gap_cnt <= 8'd1)
                    tvalid_nxt = 1'b1;
            end
            default: begin
                tvalid_nxt = 1'b0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    // Output and parameter registers; reset abandons any burst immediately.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            len_q      <= '0;
            gap_q      <= '0;
            mode_q     <= 1'b0;
            gap_cnt    <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            len_q      <= len_nxt;
            gap_q      <= gap_nxt;
            mode_q     <= mode_nxt;
            gap_cnt    <= gap_cnt_nxt;
            tvalid_q   <= tvalid_nxt;
            tdata_q    <= tdata_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            beat_cnt_q <= beat_cnt_nxt;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign beat_cnt      = beat_cnt_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_axis_pattern_master.sv
// Testbench for axis_pattern_master: driver issues bursts and pushes the
// expected byte sequence into a queue; a negedge monitor pops and compares on
// every handshake and checks gap length, hold stability and done timing.
module tb_axis_pattern_master;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic [15:0] len;
    logic [7:0]  gap;
    logic        mode;
    logic [7:0]  seed;
    logic        busy;
    logic        done;
    logic [15:0] beat_cnt;
    logic        tvalid;
    logic        tready;
    logic [7:0]  tdata;

    int n_vec;
    int n_err;

    int exp_q[$];
    int cur_len;
    int cur_gap;
    int hs_cnt;
    int bp_mode;
    int bp_cyc;
    bit exp_done_nxt;
    bit exp_done;
    bit after_beat;
    int low_cnt;
    bit prev_stall;
    int prev_data;

    axis_pattern_master #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .len           (len),
        .gap           (gap),
        .mode          (mode),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .beat_cnt      (beat_cnt),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference pattern: increment modulo 256, or shift left with feedback = parity of taps 7,5,4,3.
    function automatic int ref_next(input int m, input int d);
        int fb;
        if (m == 0) return (d + 1) % 256;
        fb = $countones(d & 8'hB8) % 2;
        return ((d * 2) % 256) + fb;
    endfunction

    // Backpressure generator: 0 = always ready, 1 = random, 2 = low 3 cycles then toggling.
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (bp_mode)
                0:       tready = 1'b1;
                1:       tready = ($urandom_range(0, 1) == 1);
                default: tready = (bp_cyc >= 3) && ((bp_cyc % 2) == 1);
            endcase
            bp_cyc++;
        end
    end

    // Monitor / scoreboard.
    always @(negedge aclk) begin
        if (!aresetn) begin
            after_beat = 0;
            prev_stall = 0;
        end else begin
            exp_done     = exp_done_nxt;
            exp_done_nxt = 0;
            chk("done", int'(done), int'(exp_done));
            if (prev_stall) begin
                chk("tvalid_hold", int'(tvalid), 1);
                chk("tdata_hold", int'(tdata), prev_data);
            end
            if (tvalid) begin
                if (after_beat) begin
                    chk("gap", low_cnt, cur_gap);
                    after_beat = 0;
                end
                if (tready) begin
                    if (exp_q.size() == 0) begin
                        chk("beat_overrun", hs_cnt + 1, cur_len);
                    end else begin
                        chk("tdata", int'(tdata), exp_q.pop_front());
                        chk("beat_cnt_pre", int'(beat_cnt), hs_cnt);
                        hs_cnt++;
                        if (exp_q.size() == 0) begin
                            exp_done_nxt = 1;
                        end else begin
                            after_beat = 1;
                            low_cnt    = 0;
                        end
                    end
                end
            end else if (after_beat) begin
                low_cnt++;
            end
            prev_stall = tvalid && !tready;
            prev_data  = int'(tdata);
        end
    end

    // Issue a burst; must be called at posedge+1, returns at posedge+1 after the accepting edge.
    task automatic start_burst(input int l, input int g, input int m, input int s, input int bp);
        int v;
        v = (m != 0 && s == 0) ? 1 : s;
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(v);
            v = ref_next(m, v);
        end
        cur_len = l;
        cur_gap = g;
        hs_cnt  = 0;
        bp_mode = bp;
        bp_cyc  = 0;
        start = 1'b1;
        len   = 16'(l);
        gap   = 8'(g);
        mode  = (m != 0);
        seed  = 8'(s);
        @(posedge aclk);
        #1;
        start = 1'b0;
        if (l == 0) begin
            exp_done_nxt = 1;
            chk("len0_busy", int'(busy), 0);
            chk("len0_tvalid", int'(tvalid), 0);
        end else begin
            chk("start_busy", int'(busy), 1);
            chk("first_tvalid", int'(tvalid), 1);
            chk("start_beat_cnt", int'(beat_cnt), 0);
        end
    endtask

    // Wait (bounded) for done, then check the completed-burst state.
    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk("done_reached", int'(done === 1'b1), 1);
        chk("final_beat_cnt", int'(beat_cnt), cur_len);
        chk("final_busy", int'(busy), 0);
        chk("final_tvalid", int'(tvalid), 0);
        chk("beats_left", exp_q.size(), 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        int n;
        n_vec = 0;
        n_err = 0;
        bp_mode = 0;
        bp_cyc = 0;
        cur_len = 0;
        cur_gap = 0;
        hs_cnt = 0;
        exp_done_nxt = 0;
        aresetn = 1'b0;
        start = 1'b0;
        len = '0;
        gap = '0;
        mode = 1'b0;
        seed = '0;
        #3;
        chk("rst_tvalid", int'(tvalid), 0);
        chk("rst_tdata", int'(tdata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_beat_cnt", int'(beat_cnt), 0);
        #20;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Zero-length burst: single done pulse, no beats.
        start_burst(0, 0, 0, 8'h55, 0);
        chk("len0_beat_cnt", int'(beat_cnt), 0);
        wait_done();
        idle_cycles(3);

        // Incrementing wrap.
        start_burst(4, 0, 0, 8'hFE, 0);
        wait_done();
        idle_cycles(2);

        // Backpressure.
        start_burst(3, 0, 0, 8'h10, 2);
        wait_done();
        idle_cycles(2);

        // Inter-beat gap.
        start_burst(3, 2, 0, 8'h00, 0);
        wait_done();
        idle_cycles(2);

        // LFSR, then a chained start in the done cycle with seed 0.
        start_burst(5, 0, 1, 8'h01, 0);
        wait_done();
        start_burst(5, 0, 1, 8'h00, 0);
        wait_done();
        idle_cycles(2);

        // start while busy is ignored.
        start_burst(5, 1, 0, 8'h30, 0);
        idle_cycles(2);
        start = 1'b1;
        len = 16'd2;
        gap = 8'd0;
        seed = 8'h99;
        @(posedge aclk);
        #1;
        start = 1'b0;
        wait_done();
        idle_cycles(2);

        // Reset mid-burst after two beats.
        start_burst(6, 0, 0, 8'h20, 0);
        n = 0;
        while (hs_cnt < 2 && n < 50) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk("pre_reset_beats", hs_cnt, 2);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", int'(tvalid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_beat_cnt", int'(beat_cnt), 0);
        exp_q.delete();
        exp_done_nxt = 0;
        idle_cycles(2);
        #2;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_tvalid", int'(tvalid), 0);
            chk("post_rst_busy", int'(busy), 0);
            @(posedge aclk);
            #1;
        end
        start_burst(3, 0, 0, 8'h40, 0);
        wait_done();
        idle_cycles(2);

        // Randomized bursts with random backpressure, some chained.
        for (int i = 0; i < 30; i++) begin
            start_burst($urandom_range(1, 10), $urandom_range(0, 3), $urandom_range(0, 1),
                        $urandom_range(0, 255), $urandom_range(0, 1));
            wait_done();
            if ($urandom_range(0, 1) == 1)
                idle_cycles($urandom_range(1, 3));
        end

        idle_cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_pattern_master.md
Name: axis_pattern_master

Overview:
- AXI4-Stream transmitter (master end) that generates a programmable byte stream for the 8-bit, TREADY-only stream interface used by the slave-side verification agents: no TLAST, TKEEP, TSTRB, TID, TDEST or TUSER.
- Sits in the testbench/bring-up path, driving DUT stream inputs or a slave VIP with incrementing or LFSR data.
- Each burst has a programmable beat count and a programmable inter-beat idle gap.
- Obeys AXI4-Stream master rules under arbitrary TREADY backpressure.

Parameters:
- DATA_WIDTH, 8, width of TDATA; LFSR mode is defined for 8 only.
- CNT_WIDTH, 16, width of the burst length and beat counters.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- start  in  1  burst request; sampled only in IDLE.
- len  in  CNT_WIDTH  beats in burst; latched at start.
- gap  in  8  idle cycles between beats; latched at start.
- mode  in  1  data pattern: 0 = incrementing, 1 = LFSR; latched at start.
- seed  in  DATA_WIDTH  first data value; latched at start.
- busy  out  1  high from the cycle after an accepted start until the burst completes.
- done  out  1  single-cycle pulse at burst completion.
- beat_cnt  out  CNT_WIDTH  handshakes completed in the current or last burst.
- m_axis_tvalid  out  1  AXI4-Stream TVALID.
- m_axis_tready  in  1  AXI4-Stream TREADY.
- m_axis_tdata  out  DATA_WIDTH  AXI4-Stream TDATA.

Behaviour:
- Reset (aresetn=0, asynchronous): state=IDLE; tvalid, tdata, busy, done and beat_cnt are all 0. All outputs are registered.
- Reset mid-burst: the burst is abandoned immediately and tvalid drops asynchronously. After release the block stays in IDLE until a new start.
- Handshake: a beat transfers on a rising edge with tvalid=1 and tready=1.
- Once tvalid=1, tvalid and tdata hold stable until that handshake. tvalid never depends combinationally on tready.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - start=1 with len!=0: latch len, gap, mode and seed; tdata<=seed (in mode 1, seed 0 is replaced by 8'h01); beat_cnt<=0; busy<=1; go to SEND. tvalid is high in the next cycle, so first-beat latency is 1 cycle.
  - start=1 with len==0: done pulses the next cycle; busy, tvalid and beat_cnt stay 0; remain in IDLE.
- SEND (tvalid=1): on each handshake, beat_cnt increments and tdata advances to the next pattern value. Then:
  - If beat_cnt+1==len: go to IDLE; tvalid<=0, busy<=0, done<=1 for exactly one cycle.
  - Else if gap!=0: go to GAP; tvalid<=0; gap counter<=gap.
  - Else: stay in SEND with tvalid=1, giving back-to-back beats at 1 beat/cycle when tready=1.
- GAP (tvalid=0): the gap counter decrements each cycle. The transition to SEND is registered on the cycle the counter is 1, so exactly gap idle cycles separate beats. tready is ignored.
- Pattern, mode 0: next = tdata+1 modulo 2^DATA_WIDTH, wrapping FF->00.
- Pattern, mode 1: next = {tdata[6:0], tdata[7]^tdata[5]^tdata[4]^tdata[3]}.
- start while busy=1 is ignored with no queueing.
- start asserted in the same cycle as done: done indicates the block is already in IDLE, so that start is accepted.
- beat_cnt holds its final value after done until the next accepted start.

Test Plan:
- Incrementing wrap: len=4, mode=0, seed=8'hFE, gap=0, tready=1 -> tdata FE,FF,00,01 on 4 consecutive cycles starting 1 cycle after start; done pulses the cycle after the 4th beat; beat_cnt=4.
- Backpressure: len=3, seed=8'h10, gap=0, tready low for 3 cycles then toggling -> tvalid stays high throughout; tdata holds 10 until its handshake, then 11, then 12; exactly 3 handshakes.
- Gap: len=3, gap=2, tready=1 -> tvalid pattern 1,0,0,1,0,0,1; done one cycle after the last beat.
- LFSR: mode=1, seed=8'h01, len=5 -> tdata 01,02,04,08,11. Repeat with seed=8'h00 -> first beat is 01.
- Edge starts: len=0 -> a single done pulse with tvalid never high. start pulsed while busy -> ignored, burst length unchanged.
- Reset mid-burst: assert aresetn=0 after 2 of 6 beats -> tvalid, busy and beat_cnt read 0 immediately. After release, a new start with seed=8'h40 begins cleanly at 40.
